// File: rtl/x25519_pkg.sv
// Shared definitions for the X25519 datapath and its result transport.
//
// Contents:
//   FIELD_W     width of a GF(2^255-19) field element
//   BYTE_W      width of one output beat
//   KEY_BYTES   bytes in an RFC 7748 u-coordinate encoding
//   SHREG_W     byte-aligned width that holds one encoded result
//   CNT_W       width of a beat index within one result
//   ser_state_t serializer FSM state encoding
package x25519_pkg;

    localparam int FIELD_W   = 255;
    localparam int BYTE_W    = 8;
    localparam int KEY_BYTES = (FIELD_W + BYTE_W - 1) / BYTE_W;
    localparam int SHREG_W   = KEY_BYTES * BYTE_W;
    localparam int CNT_W     = $clog2(KEY_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/x25519_result_serializer.sv
// x25519_result_serializer
//
// Captures a finished X25519 result on the rising edge of its valid level and
// streams it out as 32 little-endian bytes (RFC 7748 u-coordinate encoding,
// bit 255 forced to 0) over an AXI4-Stream-style byte interface.
//
// Ports:
//   ser_clk         in   clock, all logic on its rising edge
//   ser_reset       in   synchronous active-high reset
//   ser_data_in     in   255-bit field element, stable while ser_data_valid high
//   ser_data_valid  in   result-valid level; 0->1 marks a new result
//   m_tdata         out  output byte
//   m_tvalid        out  output byte valid
//   m_tready        in   downstream ready
//   m_tlast         out  high on the final (32nd) byte
//   ser_busy        out  high from capture until the last handshake
//   ser_done        out  one-cycle pulse after the last handshake
//   ser_overrun     out  sticky: a new result arrived while a stream was active
module x25519_result_serializer
    import x25519_pkg::*;
(
    input  logic               ser_clk,
    input  logic               ser_reset,
    input  logic [FIELD_W-1:0] ser_data_in,
    input  logic               ser_data_valid,
    output logic [BYTE_W-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               ser_busy,
    output logic               ser_done,
    output logic               ser_overrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_BYTES - 1);

    ser_state_t          state_reg,   state_next;
    logic [SHREG_W-1:0]  shreg_reg,   shreg_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic                overrun_reg, overrun_next;
    logic                valid_d_reg;
    logic                rise;
    logic                sending;
    logic                last_beat;

    // valid_d resets to 0, so a valid level still high when reset releases
    // is seen as a fresh result.
    assign rise      = ser_data_valid & ~valid_d_reg;
    assign sending   = (state_reg == ST_SEND);
    assign last_beat = (cnt_reg == LAST_CNT);

    always_ff @(posedge ser_clk) begin
        if (ser_reset) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            cnt_reg     <= '0;
            overrun_reg <= 1'b0;
            valid_d_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            cnt_reg     <= cnt_next;
            overrun_reg <= overrun_next;
            valid_d_reg <= ser_data_valid;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        cnt_next     = cnt_reg;
        overrun_next = overrun_reg;

        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    // Zero-extension clears bit 255 of the encoding.
                    shreg_next = SHREG_W'(ser_data_in);
                    cnt_next   = '0;
                    state_next = ST_SEND;
                end
            end

            ST_SEND: begin
                // A new result during a stream is dropped; the stream in
                // flight carries on with the value already captured.
                if (rise) begin
                    overrun_next = 1'b1;
                end
                if (m_tready) begin
                    shreg_next = shreg_reg >> BYTE_W;
                    // Wraps 31 -> 0 on the final handshake.
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (last_beat) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (rise) begin
                    overrun_next = 1'b1;
                end
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so m_tvalid never depends on
    // m_tready and beat contents hold steady through stalls.
    assign m_tvalid    = sending;
    assign m_tdata     = sending ? shreg_reg[BYTE_W-1:0] : '0;
    assign m_tlast     = sending & last_beat;
    assign ser_busy    = sending;
    assign ser_done    = (state_reg == ST_DONE);
    assign ser_overrun = overrun_reg;

endmodule

// File: tb/tb_x25519_result_serializer.sv
module tb_x25519_result_serializer;

    logic         ser_clk = 1'b0;
    logic         ser_reset;
    logic [254:0] ser_data_in;
    logic         ser_data_valid;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         ser_busy;
    logic         ser_done;
    logic         ser_overrun;

    int errors = 0;
    int checks = 0;

    x25519_result_serializer dut (
        .ser_clk        (ser_clk),
        .ser_reset      (ser_reset),
        .ser_data_in    (ser_data_in),
        .ser_data_valid (ser_data_valid),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .ser_busy       (ser_busy),
        .ser_done       (ser_done),
        .ser_overrun    (ser_overrun)
    );

    always #5 ser_clk = ~ser_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoding: beat k is byte k of the value read as a 256-bit
    // little-endian integer whose top bit is zero.
    function automatic logic [7:0] ref_byte(input logic [254:0] val, input int k);
        logic [255:0] v;
        v = {1'b0, val};
        return 8'((v >> (8 * k)) & 256'hFF);
    endfunction

    function automatic logic [254:0] rand_field();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r[254:0];
    endfunction

    // mode: 0 ready always high, 1 ready toggles 1,0,1,0, 2 random ready.
    // abort_at >= 0: reset when that beat is presented.
    // ovr_at >= 0: drop valid then raise it with val2 when that beat is presented.
    task automatic run_stream(input logic [254:0] val, input int mode,
                              input int abort_at, input int ovr_at,
                              input logic [254:0] val2,
                              output logic [7:0] first_b, output logic [7:0] last_b);
        logic [7:0] exp_q[$];
        logic [7:0] prev;
        bit         stalled;
        int         idx;
        int         k;
        int         ovr_phase;
        bit         tr;
        exp_q.delete();
        for (int b = 0; b < 32; b++) exp_q.push_back(ref_byte(val, b));
        first_b = 8'h00;
        last_b = 8'h00;
        stalled = 1'b0;
        prev = 8'h00;
        idx = 0;
        k = 0;
        ovr_phase = 0;

        @(negedge ser_clk);
        ser_data_in = val;
        ser_data_valid = 1'b1;
        m_tready = 1'b0;

        while (idx < 32 && k < 400) begin
            @(negedge ser_clk);
            k++;
            if (k == 1) chk("first_beat_latency", 32'(m_tvalid), 32'd1);
            else        chk("tvalid_hold", 32'(m_tvalid), 32'd1);
            chk("busy", 32'(ser_busy), 32'd1);
            chk($sformatf("tdata_beat%0d", idx), 32'(m_tdata), 32'(exp_q[idx]));
            chk($sformatf("tlast_beat%0d", idx), 32'(m_tlast), 32'(idx == 31));
            if (stalled) chk("stall_stable", 32'(m_tdata), 32'(prev));

            if (abort_at == idx) begin
                ser_reset = 1'b1;
                ser_data_valid = 1'b0;
                m_tready = 1'b0;
                @(negedge ser_clk);
                chk("abort_tvalid", 32'(m_tvalid), 32'd0);
                chk("abort_tlast", 32'(m_tlast), 32'd0);
                chk("abort_busy", 32'(ser_busy), 32'd0);
                chk("abort_overrun", 32'(ser_overrun), 32'd0);
                ser_reset = 1'b0;
                $display("stream aborted by reset at beat %0d", idx);
                return;
            end

            if (ovr_phase == 0 && ovr_at == idx) begin
                ser_data_valid = 1'b0;
                ovr_phase = 1;
            end else if (ovr_phase == 1) begin
                ser_data_in = val2;
                ser_data_valid = 1'b1;
                ovr_phase = 2;
            end

            case (mode)
                0:       tr = 1'b1;
                1:       tr = (k % 2) == 1;
                default: tr = 1'($urandom_range(0, 1));
            endcase
            m_tready = tr;
            prev = m_tdata;
            stalled = !tr;
            if (tr && m_tvalid) begin
                if (idx == 0)  first_b = m_tdata;
                if (idx == 31) last_b = m_tdata;
                idx++;
            end
        end

        if (idx < 32) begin
            chk("stream_timeout", 32'(idx), 32'd32);
            ser_data_valid = 1'b0;
            return;
        end

        @(negedge ser_clk);
        k++;
        m_tready = 1'b0;
        chk("done_pulse", 32'(ser_done), 32'd1);
        chk("done_tvalid", 32'(m_tvalid), 32'd0);
        chk("done_busy", 32'(ser_busy), 32'd0);
        chk("done_tlast", 32'(m_tlast), 32'd0);
        if (mode == 0 && ovr_at < 0) chk("done_latency", 32'(k), 32'd33);
        ser_data_valid = 1'b0;
        @(negedge ser_clk);
        chk("done_one_cycle", 32'(ser_done), 32'd0);
        $display("stream mode=%0d first=%02h last=%02h cycles=%0d", mode, first_b, last_b, k);
    endtask

    typedef struct {
        string        name;
        logic [254:0] data;
        int           mode;
        logic [7:0]   b0;
        logic [7:0]   b31;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [255:0] pat;
        logic [7:0]   f, l;
        logic [254:0] va, vb;

        for (int b = 0; b < 32; b++) pat[8*b +: 8] = 8'(32 - b);
        vecs[0] = '{"nine",     255'd9,       0, 8'h09, 8'h00};
        vecs[1] = '{"allones",  {255{1'b1}},  0, 8'hFF, 8'h7F};
        vecs[2] = '{"pattern",  pat[254:0],   1, 8'h20, 8'h01};

        // Reset with random inputs.
        ser_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ser_data_in = rand_field();
            ser_data_valid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            @(negedge ser_clk);
            chk("rst_tvalid", 32'(m_tvalid), 32'd0);
            chk("rst_tdata", 32'(m_tdata), 32'd0);
            chk("rst_tlast", 32'(m_tlast), 32'd0);
            chk("rst_busy", 32'(ser_busy), 32'd0);
            chk("rst_done", 32'(ser_done), 32'd0);
            chk("rst_overrun", 32'(ser_overrun), 32'd0);
        end
        ser_data_valid = 1'b0;
        @(negedge ser_clk);
        ser_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ser_data_in = rand_field();
            m_tready = 1'($urandom_range(0, 1));
            @(negedge ser_clk);
            chk("idle_no_beat", 32'(m_tvalid), 32'd0);
        end

        // Directed table.
        for (int i = 0; i < 3; i++) begin
            run_stream(vecs[i].data, vecs[i].mode, -1, -1, '0, f, l);
            chk({vecs[i].name, "_first"}, 32'(f), 32'(vecs[i].b0));
            chk({vecs[i].name, "_last"}, 32'(l), 32'(vecs[i].b31));
        end
        chk("no_overrun_yet", 32'(ser_overrun), 32'd0);

        // Overrun: second result arrives at beat 10.
        va = rand_field();
        vb = rand_field();
        run_stream(va, 0, -1, 10, vb, f, l);
        chk("overrun_set", 32'(ser_overrun), 32'd1);
        repeat (5) @(negedge ser_clk);
        chk("overrun_sticky", 32'(ser_overrun), 32'd1);

        // Reset mid-stream, then restart from byte 0 with a new value.
        run_stream(va, 0, 10, -1, '0, f, l);
        run_stream(vb, 0, -1, -1, '0, f, l);
        chk("restart_first", 32'(f), 32'(ref_byte(vb, 0)));

        // Randomized streams with random back-pressure.
        for (int i = 0; i < 20; i++) begin
            va = rand_field();
            run_stream(va, 2, -1, -1, '0, f, l);
        end
        chk("final_no_overrun", 32'(ser_overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
